// File: rtl/axi4_lite_mst_arbiter_if.sv
// AXI4-Lite bundle shared between a master and a slave.
//   mst modport: drives AW/W/AR channels and B/R ready.
//   slv modport: drives AW/W/AR ready and the B/R channels.
interface axi4_lite_if #(
  parameter int unsigned AXI4_LITE_ADDR_BIT_WIDTH = 4,
  parameter int unsigned AXI4_LITE_DATA_BIT_WIDTH = 32
);
  logic                                  awvalid;
  logic                                  awready;
  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   awaddr;
  logic [2:0]                            awprot;
  logic                                  wvalid;
  logic                                  wready;
  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   wdata;
  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0] wstrb;
  logic                                  bvalid;
  logic                                  bready;
  logic [1:0]                            bresp;
  logic                                  arvalid;
  logic                                  arready;
  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   araddr;
  logic [2:0]                            arprot;
  logic                                  rvalid;
  logic                                  rready;
  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   rdata;
  logic [1:0]                            rresp;

  modport mst (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slv (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_mst_arbiter.sv
// Round-robin arbiter that turns simple register-access requests from N_REQ requesters into
// single-beat AXI4-Lite writes/reads on one master port.
//   i_clk, i_sync_rst   : clock, synchronous active-high reset
//   i_req/i_we          : per-requester request level and direction (1 = write)
//   i_addr/i_wdata      : per-requester address/write data, requester k uses slice k
//   o_ack               : one-hot single-cycle completion pulse
//   o_rdata/o_resp      : last read data / last BRESP or RRESP, valid with o_ack
//   o_busy              : high whenever a transaction is in flight
//   if_m_axi4_lite      : AXI4-Lite master port
module axi4_lite_mst_arbiter #(
  parameter int unsigned N_REQ                    = 2,
  parameter int unsigned AXI4_LITE_ADDR_BIT_WIDTH = 4,
  parameter int unsigned AXI4_LITE_DATA_BIT_WIDTH = 32
) (
  input  logic                                        i_clk,
  input  logic                                        i_sync_rst,
  input  logic [N_REQ-1:0]                            i_req,
  input  logic [N_REQ-1:0]                            i_we,
  input  logic [N_REQ*AXI4_LITE_ADDR_BIT_WIDTH-1:0]   i_addr,
  input  logic [N_REQ*AXI4_LITE_DATA_BIT_WIDTH-1:0]   i_wdata,
  output logic [N_REQ-1:0]                            o_ack,
  output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]         o_rdata,
  output logic [1:0]                                  o_resp,
  output logic                                        o_busy,
  axi4_lite_if.mst                                    if_m_axi4_lite
);
  localparam int unsigned AW = AXI4_LITE_ADDR_BIT_WIDTH;
  localparam int unsigned DW = AXI4_LITE_DATA_BIT_WIDTH;
  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {StIdle, StWrAwW, StWrB, StRdAr, StRdR, StAck} state_e;

  state_e            state_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     grant_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic              arvalid_q;
  logic              rready_q;
  logic [N_REQ-1:0]  ack_q;
  logic [DW-1:0]     rdata_q;
  logic [1:0]        resp_q;

  // First requesting index at or after ptr_q, wrapping around.
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  int unsigned   cand;
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (32'(ptr_q) + i) % N_REQ;
      if (!pick_valid && i_req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

  // A valid that is still outstanding after this edge; both zero means AW and W are done.
  logic aw_left;
  logic w_left;
  assign aw_left = awvalid_q && !if_m_axi4_lite.awready;
  assign w_left  = wvalid_q && !if_m_axi4_lite.wready;

  logic [IW-1:0] ptr_next;
  assign ptr_next = IW'((32'(grant_q) + 1) % N_REQ);

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= '0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            grant_q <= pick_idx;
            addr_q  <= i_addr[pick_idx*AW +: AW];
            wdata_q <= i_wdata[pick_idx*DW +: DW];
            if (i_we[pick_idx]) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= StWrAwW;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= StRdAr;
            end
          end
        end
        StWrAwW: begin
          // Each valid falls on its own handshake; AW and W may finish in any order.
          if (!aw_left) awvalid_q <= 1'b0;
          if (!w_left)  wvalid_q  <= 1'b0;
          if (!aw_left && !w_left) begin
            bready_q <= 1'b1;
            state_q  <= StWrB;
          end
        end
        StWrB: begin
          if (if_m_axi4_lite.bvalid) begin
            resp_q   <= if_m_axi4_lite.bresp;
            bready_q <= 1'b0;
            ack_q    <= N_REQ'(1) << grant_q;
            state_q  <= StAck;
          end
        end
        StRdAr: begin
          if (if_m_axi4_lite.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdR;
          end
        end
        StRdR: begin
          if (if_m_axi4_lite.rvalid) begin
            rdata_q  <= if_m_axi4_lite.rdata;
            resp_q   <= if_m_axi4_lite.rresp;
            rready_q <= 1'b0;
            ack_q    <= N_REQ'(1) << grant_q;
            state_q  <= StAck;
          end
        end
        StAck: begin
          ptr_q   <= ptr_next;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign if_m_axi4_lite.awvalid = awvalid_q;
  assign if_m_axi4_lite.awaddr  = addr_q;
  assign if_m_axi4_lite.awprot  = 3'b000;
  assign if_m_axi4_lite.wvalid  = wvalid_q;
  assign if_m_axi4_lite.wdata   = wdata_q;
  assign if_m_axi4_lite.wstrb   = '1;
  assign if_m_axi4_lite.bready  = bready_q;
  assign if_m_axi4_lite.arvalid = arvalid_q;
  assign if_m_axi4_lite.araddr  = addr_q;
  assign if_m_axi4_lite.arprot  = 3'b000;
  assign if_m_axi4_lite.rready  = rready_q;

  assign o_ack   = ack_q;
  assign o_rdata = rdata_q;
  assign o_resp  = resp_q;
  assign o_busy  = (state_q != StIdle);
endmodule
